// File: rtl/baud_gen_frac.sv
// Fractional baud-rate generator.
// Produces an oversample tick (os_tick) and a bit tick (baud_tick) from a
// divisor of the form div + frac/OS. A phase accumulator spreads the
// fractional part across the OS oversample periods of a bit. Every bit
// therefore lasts exactly OS*div + frac enabled cycles.
module baud_gen_frac #(
  parameter int OS    = 16,
  parameter int DIV_W = 14,
  parameter int DIV0  = 812,
  parameter int FRAC0 = 12,
  parameter int DIV1  = 40,
  parameter int FRAC1 = 12,
  parameter int DIV2  = 20,
  parameter int FRAC2 = 7,
  parameter int DIV3  = 10,
  parameter int FRAC3 = 3
) (
  input  logic                    clock,
  input  logic                    rst,
  input  logic                    en,
  input  logic                    sync,
  input  logic [1:0]              baud_rate,
  input  logic                    custom_en,
  input  logic [DIV_W-1:0]        custom_div,
  input  logic [$clog2(OS)-1:0]   custom_frac,
  output logic                    os_tick,
  output logic                    baud_tick,
  output logic [$clog2(OS)-1:0]   os_phase,
  output logic                    cfg_err
);

  localparam int FRAC_W = $clog2(OS);

  // Divisor of the power-on configuration, clamped like any other load.
  localparam logic [DIV_W-1:0] RST_DIV  = (DIV0 < 2) ? DIV_W'(2) : DIV_W'(DIV0);
  localparam logic [FRAC_W-1:0] RST_FRAC = FRAC_W'(FRAC0);
  localparam logic [FRAC_W-1:0] LAST_PH  = FRAC_W'(OS - 1);

  // Selected source (sampled only on load events)
  logic [DIV_W-1:0]  sel_div;
  logic [FRAC_W-1:0] sel_frac;
  logic              sel_clamp;
  logic [DIV_W-1:0]  sel_eff;

  // State
  logic [DIV_W-1:0]  cnt_reg, cnt_next;
  logic [FRAC_W-1:0] acc_reg, acc_next;
  logic [FRAC_W-1:0] ph_reg, ph_next;
  logic [DIV_W-1:0]  div_reg, div_next;
  logic [FRAC_W-1:0] frac_reg, frac_next;
  logic              load_pending_reg, load_pending_next;
  logic              os_tick_reg, os_tick_next;
  logic              baud_tick_reg, baud_tick_next;
  logic [FRAC_W-1:0] os_phase_reg, os_phase_next;
  logic              cfg_err_reg, cfg_err_next;

  // Decoded events
  logic              term;
  logic              is_baud;
  logic              load;
  logic [FRAC_W:0]   acc_sum;
  logic              carry;

  // Pick the divisor source: custom registers or one of four presets.
  always_comb begin
    sel_div  = DIV_W'(DIV0);
    sel_frac = FRAC_W'(FRAC0);
    if (custom_en) begin
      sel_div  = custom_div;
      sel_frac = custom_frac;
    end else begin
      case (baud_rate)
        2'd0: begin sel_div = DIV_W'(DIV0); sel_frac = FRAC_W'(FRAC0); end
        2'd1: begin sel_div = DIV_W'(DIV1); sel_frac = FRAC_W'(FRAC1); end
        2'd2: begin sel_div = DIV_W'(DIV2); sel_frac = FRAC_W'(FRAC2); end
        default: begin sel_div = DIV_W'(DIV3); sel_frac = FRAC_W'(FRAC3); end
      endcase
    end
  end

  // A divisor below 2 cannot produce distinct ticks; clamp and flag it.
  assign sel_clamp = (sel_div < DIV_W'(2));
  assign sel_eff   = sel_clamp ? DIV_W'(2) : sel_div;

  // Terminal count, bit boundary and fractional carry.
  assign term    = en && !sync && !load_pending_reg && (cnt_reg == '0);
  assign is_baud = term && (ph_reg == LAST_PH);
  assign load    = sync || (en && load_pending_reg) || is_baud;
  assign acc_sum = {1'b0, acc_reg} + {1'b0, frac_reg};
  assign carry   = acc_sum[FRAC_W];

  // Next-state: sync beats terminal count; en low freezes everything.
  always_comb begin
    cnt_next          = cnt_reg;
    acc_next          = acc_reg;
    ph_next           = ph_reg;
    div_next          = div_reg;
    frac_next         = frac_reg;
    load_pending_next = load_pending_reg;
    os_tick_next      = 1'b0;
    baud_tick_next    = 1'b0;
    os_phase_next     = os_phase_reg;
    cfg_err_next      = cfg_err_reg;

    if (load) begin
      div_next     = sel_eff;
      frac_next    = sel_frac;
      cfg_err_next = sel_clamp;
    end

    if (sync) begin
      cnt_next          = sel_eff - DIV_W'(1);
      acc_next          = '0;
      ph_next           = '0;
      os_phase_next     = '0;
      load_pending_next = 1'b0;
    end else if (en) begin
      if (load_pending_reg) begin
        cnt_next          = sel_eff - DIV_W'(1);
        load_pending_next = 1'b0;
      end else if (cnt_reg == '0) begin
        os_tick_next   = 1'b1;
        baud_tick_next = is_baud;
        acc_next       = acc_sum[FRAC_W-1:0];
        ph_next        = ph_reg + FRAC_W'(1);
        // os_phase reports the slot of the tick just emitted, so it reads
        // OS-1 while baud_tick is high.
        os_phase_next  = ph_reg;
        // At a bit boundary the new divisor takes over immediately; the
        // carry is the last fractional cycle owed by the finishing bit.
        if (is_baud) begin
          cnt_next = sel_eff - DIV_W'(1) + DIV_W'(carry);
        end else begin
          cnt_next = div_reg - DIV_W'(1) + DIV_W'(carry);
        end
      end else begin
        cnt_next = cnt_reg - DIV_W'(1);
      end
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clock or posedge rst) begin
    if (rst) begin
      cnt_reg          <= '0;
      acc_reg          <= '0;
      ph_reg           <= '0;
      div_reg          <= RST_DIV;
      frac_reg         <= RST_FRAC;
      load_pending_reg <= 1'b1;
      os_tick_reg      <= 1'b0;
      baud_tick_reg    <= 1'b0;
      os_phase_reg     <= '0;
      cfg_err_reg      <= 1'b0;
    end else begin
      cnt_reg          <= cnt_next;
      acc_reg          <= acc_next;
      ph_reg           <= ph_next;
      div_reg          <= div_next;
      frac_reg         <= frac_next;
      load_pending_reg <= load_pending_next;
      os_tick_reg      <= os_tick_next;
      baud_tick_reg    <= baud_tick_next;
      os_phase_reg     <= os_phase_next;
      cfg_err_reg      <= cfg_err_next;
    end
  end

  assign os_tick   = os_tick_reg;
  assign baud_tick = baud_tick_reg;
  assign os_phase  = os_phase_reg;
  assign cfg_err   = cfg_err_reg;

endmodule

// File: tb/tb_baud_gen_frac.sv
// Self-checking bench for baud_gen_frac: expected tick times are computed
// from the divisor arithmetic and queued, then matched against DUT ticks.
module tb_baud_gen_frac;

  localparam int OS    = 16;
  localparam int DIV_W = 14;
  localparam int FW    = 4;

  logic             clock = 1'b0;
  logic             rst;
  logic             en;
  logic             sync;
  logic [1:0]       baud_rate;
  logic             custom_en;
  logic [DIV_W-1:0] custom_div;
  logic [FW-1:0]    custom_frac;
  logic             os_tick;
  logic             baud_tick;
  logic [FW-1:0]    os_phase;
  logic             cfg_err;

  baud_gen_frac #(.OS(OS), .DIV_W(DIV_W)) dut (
    .clock       (clock),
    .rst         (rst),
    .en          (en),
    .sync        (sync),
    .baud_rate   (baud_rate),
    .custom_en   (custom_en),
    .custom_div  (custom_div),
    .custom_frac (custom_frac),
    .os_tick     (os_tick),
    .baud_tick   (baud_tick),
    .os_phase    (os_phase),
    .cfg_err     (cfg_err)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int n_vec = 0;
  int n_bad = 0;
  int last_baud = 0;

  typedef struct {
    int t;
    int ph;
    bit bd;
  } exp_t;
  exp_t exp_q[$];

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    int seen;
    rst = 1'b1; en = 1'b0; sync = 1'b0; baud_rate = 2'd0;
    custom_en = 1'b0; custom_div = '0; custom_frac = '0;
    repeat (3) step();
    n_vec++; if (os_tick !== 1'b0) begin n_bad++; $display("FAIL reset_os_tick got=%b want=0", os_tick); end
    n_vec++; if (baud_tick !== 1'b0) begin n_bad++; $display("FAIL reset_baud_tick got=%b want=0", baud_tick); end
    n_vec++; if (os_phase !== 4'd0) begin n_bad++; $display("FAIL reset_os_phase got=%0d want=0", os_phase); end
    n_vec++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL reset_cfg_err got=%b want=0", cfg_err); end
    rst = 1'b0;
    seen = 0;
    repeat (20) begin step(); if (os_tick) seen++; end
    n_vec++; if (seen !== 0) begin n_bad++; $display("FAIL disabled_ticks got=%0d want=0", seen); end
    $display("reset: outputs idle, %0d ticks while disabled", seen);
  endtask

  task automatic test_preset3();
    int t0, t, acc, c, first_b;
    exp_t e;
    baud_rate = 2'd3; en = 1'b1;
    step();                      // load edge
    t0 = cyc;
    acc = 0; t = t0 + 10;
    for (int k = 1; k <= 32; k++) begin
      e.t = t; e.ph = (k - 1) % OS; e.bd = (k % OS) == 0;
      exp_q.push_back(e);
      acc += 3; c = (acc >= OS) ? 1 : 0; if (c == 1) acc -= OS;
      t += 10 + c;
    end
    first_b = 0;
    for (int i = 0; i < 500 && exp_q.size() > 0; i++) begin
      step();
      if (os_tick) begin
        e = exp_q.pop_front();
        n_vec++;
        if (cyc !== e.t || os_phase !== e.ph || baud_tick !== e.bd) begin
          n_bad++;
          $display("FAIL preset3_tick got t=%0d ph=%0d bd=%b want t=%0d ph=%0d bd=%b",
                   cyc - t0, os_phase, baud_tick, e.t - t0, e.ph, e.bd);
        end
        $display("preset3: os_tick at +%0d phase %0d baud %b", cyc - t0, os_phase, baud_tick);
        if (baud_tick) begin
          if (first_b != 0) begin
            n_vec++;
            if (cyc - first_b !== 163) begin n_bad++; $display("FAIL preset3_bit got=%0d want=163", cyc - first_b); end
          end
          first_b = cyc;
          last_baud = cyc;
        end
      end else if (baud_tick) begin
        n_vec++; n_bad++; $display("FAIL preset3_stray_baud got=1 want=0");
      end
    end
    if (exp_q.size() > 0) begin
      n_vec++; n_bad++; $display("FAIL preset3_timeout got=%0d pending want=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_switch();
    exp_t e;
    repeat (50) step();
    baud_rate = 2'd1;            // mid-bit change, takes effect at next bit
    e.ph = OS - 1; e.bd = 1'b1;
    e.t = last_baud + 163;       exp_q.push_back(e);
    e.t = last_baud + 163 + 652; exp_q.push_back(e);
    for (int i = 0; i < 900 && exp_q.size() > 0; i++) begin
      step();
      if (baud_tick) begin
        e = exp_q.pop_front();
        n_vec++;
        if (cyc !== e.t || os_phase !== e.ph) begin
          n_bad++;
          $display("FAIL switch_baud got t=%0d ph=%0d want t=%0d ph=%0d", cyc, os_phase, e.t, e.ph);
        end
        $display("switch: baud_tick after %0d cycles", cyc - last_baud);
        last_baud = cyc;
      end
    end
    if (exp_q.size() > 0) begin
      n_vec++; n_bad++; $display("FAIL switch_timeout got=%0d pending want=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_preset0();
    int t0, t, acc, c, nos;
    exp_t e;
    rst = 1'b1; step(); rst = 1'b0;
    baud_rate = 2'd0; en = 1'b1;
    step();                      // load edge
    t0 = cyc;
    acc = 0; t = t0 + 812;
    for (int k = 1; k < OS; k++) begin
      acc += 12; c = (acc >= OS) ? 1 : 0; if (c == 1) acc -= OS;
      t += 812 + c;
    end
    e.ph = OS - 1; e.bd = 1'b1;
    for (int b = 0; b < 3; b++) begin e.t = t + b * 13004; exp_q.push_back(e); end
    nos = 0;
    for (int i = 0; i < 40000 && exp_q.size() > 0; i++) begin
      step();
      if (os_tick) nos++;
      if (baud_tick) begin
        e = exp_q.pop_front();
        n_vec++;
        if (cyc !== e.t || os_phase !== e.ph) begin
          n_bad++;
          $display("FAIL preset0_baud got t=%0d ph=%0d want t=%0d ph=%0d", cyc - t0, os_phase, e.t - t0, e.ph);
        end
        n_vec++;
        if (nos !== OS) begin n_bad++; $display("FAIL preset0_os_count got=%0d want=%0d", nos, OS); end
        $display("preset0: baud_tick at +%0d, %0d os ticks in bit", cyc - t0, nos);
        nos = 0;
      end
    end
    if (exp_q.size() > 0) begin
      n_vec++; n_bad++; $display("FAIL preset0_timeout got=%0d pending want=0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_custom();
    int ts, t, acc, c, first_b;
    exp_t e;
    custom_en = 1'b1; custom_div = 14'd1; custom_frac = 4'd5;
    sync = 1'b1; step(); sync = 1'b0;
    ts = cyc;
    n_vec++; if (cfg_err !== 1'b1) begin n_bad++; $display("FAIL custom_cfg_err got=%b want=1", cfg_err); end
    acc = 0; t = ts + 2;
    for (int k = 1; k <= 32; k++) begin
      e.t = t; e.ph = (k - 1) % OS; e.bd = (k % OS) == 0;
      exp_q.push_back(e);
      acc += 5; c = (acc >= OS) ? 1 : 0; if (c == 1) acc -= OS;
      t += 2 + c;
    end
    first_b = 0;
    for (int i = 0; i < 200 && exp_q.size() > 0; i++) begin
      step();
      if (os_tick) begin
        e = exp_q.pop_front();
        n_vec++;
        if (cyc !== e.t || os_phase !== e.ph || baud_tick !== e.bd) begin
          n_bad++;
          $display("FAIL custom_tick got t=%0d ph=%0d bd=%b want t=%0d ph=%0d bd=%b",
                   cyc - ts, os_phase, baud_tick, e.t - ts, e.ph, e.bd);
        end
        if (baud_tick) begin
          if (first_b != 0) begin
            n_vec++;
            if (cyc - first_b !== 37) begin n_bad++; $display("FAIL custom_bit got=%0d want=37", cyc - first_b); end
          end
          $display("custom: baud_tick at +%0d", cyc - ts);
          first_b = cyc;
        end
      end
    end
    if (exp_q.size() > 0) begin
      n_vec++; n_bad++; $display("FAIL custom_timeout got=%0d pending want=0", exp_q.size());
      exp_q.delete();
    end
    custom_en = 1'b0;
  endtask

  task automatic test_sync();
    int k;
    baud_rate = 2'd3;
    sync = 1'b1; step(); sync = 1'b0;
    n_vec++; if (cfg_err !== 1'b0) begin n_bad++; $display("FAIL sync_cfg_err got=%b want=0", cfg_err); end
    // Ticks after sync land at +10..+60, +71, +81, +91 (carry after tick 6).
    repeat (90) step();
    n_vec++; if (os_phase !== 4'd7) begin n_bad++; $display("FAIL sync_align_phase got=%0d want=7", os_phase); end
    sync = 1'b1; step(); sync = 1'b0;   // lands on the terminal-count edge
    n_vec++;
    if (os_tick !== 1'b0 || baud_tick !== 1'b0 || os_phase !== 4'd0) begin
      n_bad++;
      $display("FAIL sync_suppress got os=%b bd=%b ph=%0d want os=0 bd=0 ph=0", os_tick, baud_tick, os_phase);
    end
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (os_tick) begin k = i; break; end
    end
    n_vec++; if (k !== 10) begin n_bad++; $display("FAIL sync_next_tick got=%0d want=10", k); end
    n_vec++; if (os_phase !== 4'd0) begin n_bad++; $display("FAIL sync_next_phase got=%0d want=0", os_phase); end
    $display("sync: next os_tick %0d cycles after sync, phase %0d", k, os_phase);
  endtask

  task automatic test_pause_and_rst();
    int t_tick, seen, k;
    t_tick = cyc;                 // just after first os_tick following sync
    repeat (4) step();
    en = 1'b0;
    seen = 0;
    repeat (50) begin step(); if (os_tick || baud_tick) seen++; end
    n_vec++; if (seen !== 0) begin n_bad++; $display("FAIL pause_ticks got=%0d want=0", seen); end
    en = 1'b1;
    k = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (os_tick) begin k = cyc - t_tick; break; end
    end
    n_vec++; if (k !== 60) begin n_bad++; $display("FAIL pause_period got=%0d want=60", k); end
    $display("pause: period stretched to %0d cycles", k);
    // os_tick=1 and os_phase=1 right now; reset must clear them without an edge.
    rst = 1'b1;
    #1;
    n_vec++;
    if (os_tick !== 1'b0 || os_phase !== 4'd0 || baud_tick !== 1'b0 || cfg_err !== 1'b0) begin
      n_bad++;
      $display("FAIL rst_async got os=%b ph=%0d bd=%b err=%b want all 0", os_tick, os_phase, baud_tick, cfg_err);
    end
    seen = 0;
    repeat (3) begin step(); if (os_tick) seen++; end
    rst = 1'b0;
    step();                        // load edge
    k = 0;
    for (int i = 1; i <= 40; i++) begin
      step();
      if (os_tick) seen++;
      if (os_tick) begin k = i; break; end
    end
    n_vec++; if (k !== 10) begin n_bad++; $display("FAIL rst_first_tick got=%0d want=10", k); end
    n_vec++; if (seen !== 1) begin n_bad++; $display("FAIL rst_tick_count got=%0d want=1", seen); end
    $display("rst: first os_tick %0d cycles after load", k);
  endtask

  initial begin
    test_reset();
    test_preset3();
    test_switch();
    test_preset0();
    test_custom();
    test_sync();
    test_pause_and_rst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
